// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS unified memory responder.
package mips_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} mem_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_BOTH     = 2'b11;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // {out_of_range, misaligned}; offset wraps modulo 2^32 so addresses below base are out of range
  function automatic logic [1:0] fault_cause(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return {((off >> 2) >= depth), (addr[1:0] != 2'b00)};
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word storage: async fetch read, registered data read, two write lanes (lane 0 wins on same index).
module mips_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       i_fa_idx,
  output logic [31:0]         o_fa_data,
  input  logic [AW-1:0]       i_rd_idx,
  input  logic                i_rd_zero,
  output logic [31:0]         o_rd_data,
  input  logic [1:0]          i_we,
  input  logic [1:0][AW-1:0]  i_wa,
  input  logic [1:0][31:0]    i_wd
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we[1]) r_mem[i_wa[1]] <= i_wd[1];
    if (i_we[0]) r_mem[i_wa[0]] <= i_wd[0];
  end

  assign o_fa_data = r_mem[i_fa_idx];

  // Read-before-write: a store cycle returns the word as it was before the store
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rd_data <= '0;
    else if (i_rd_zero) r_rd_data <= '0;
    else                r_rd_data <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mips_memory.sv
// Unified instruction/data memory for the MIPS core with clear sequencer, host preload and fault capture.
module mips_memory
  import mips_pkg::*;
#(
  parameter logic [31:0] base_addr      = 32'h0000_0000,
  parameter int          depth_words    = 1024,
  parameter bit          clear_on_reset = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic        data_rd_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        ready,
  output logic        load_collision,
  output logic        err_flag,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);

  localparam int          AW      = $clog2(depth_words);
  localparam logic [31:0] DEPTH32 = depth_words;

  mem_state_t r_state, w_next;
  logic [AW-1:0] r_clr_idx;
  logic          r_ready, r_coll, r_err_flag;
  logic [1:0]    r_err_cause;
  logic [31:0]   r_err_addr;

  logic [AW-1:0] w_i_idx, w_d_idx, w_h_idx;
  logic [1:0]    w_i_cause, w_d_cause, w_h_cause;
  logic          w_run, w_clr_wr, w_st, w_ld, w_same, w_coll;
  logic [31:0]   w_fa_data;
  logic [1:0]         w_we;
  logic [1:0][AW-1:0] w_wa;
  logic [1:0][31:0]   w_wd;
  logic          w_fault;
  logic [1:0]    w_fcause;
  logic [31:0]   w_faddr;

  assign w_i_idx   = AW'((instr_addr - base_addr) >> 2);
  assign w_d_idx   = AW'((data_addr  - base_addr) >> 2);
  assign w_h_idx   = AW'((load_addr  - base_addr) >> 2);
  assign w_i_cause = fault_cause(instr_addr, base_addr, DEPTH32);
  assign w_d_cause = fault_cause(data_addr,  base_addr, DEPTH32);
  assign w_h_cause = fault_cause(load_addr,  base_addr, DEPTH32);

  assign w_run    = (r_state == RUN);
  assign w_clr_wr = (r_state == CLEAR) && clear_on_reset;
  assign w_st     = w_run && (data_rd_wr == MEM_WRITE) && (w_d_cause == ERR_NONE);
  assign w_ld     = w_run && load_en && (w_h_cause == ERR_NONE);
  assign w_same   = (w_d_idx == w_h_idx);
  assign w_coll   = w_st && w_ld && w_same;

  always_comb begin
    w_next = r_state;
    if (r_state == CLEAR && (!clear_on_reset || r_clr_idx == AW'(depth_words - 1)))
      w_next = RUN;
  end

  // Lane 0 carries clear, core store, or a lone host load; lane 1 only a host load beside a store
  always_comb begin
    w_we = '0;
    w_wa = '0;
    w_wd = '0;
    if (w_clr_wr) begin
      w_we[0] = 1'b1; w_wa[0] = r_clr_idx;
    end else if (w_st) begin
      w_we[0] = 1'b1; w_wa[0] = w_d_idx; w_wd[0] = data_out;
    end else if (w_ld) begin
      w_we[0] = 1'b1; w_wa[0] = w_h_idx; w_wd[0] = load_data;
    end
    if (w_st && w_ld && !w_same) begin
      w_we[1] = 1'b1; w_wa[1] = w_h_idx; w_wd[1] = load_data;
    end
  end

  always_comb begin
    w_fault  = 1'b0;
    w_fcause = ERR_NONE;
    w_faddr  = '0;
    if (w_d_cause != ERR_NONE) begin
      w_fault = 1'b1; w_fcause = w_d_cause; w_faddr = data_addr;
    end else if (w_i_cause != ERR_NONE) begin
      w_fault = 1'b1; w_fcause = w_i_cause; w_faddr = instr_addr;
    end else if (load_en && w_h_cause != ERR_NONE) begin
      w_fault = 1'b1; w_fcause = w_h_cause; w_faddr = load_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CLEAR;
      r_clr_idx   <= '0;
      r_ready     <= 1'b0;
      r_coll      <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_cause <= ERR_NONE;
      r_err_addr  <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == RUN);
      r_coll  <= w_coll;
      if (w_clr_wr) r_clr_idx <= r_clr_idx + 1'b1;
      if (w_run && !r_err_flag && w_fault) begin
        r_err_flag  <= 1'b1;
        r_err_cause <= w_fcause;
        r_err_addr  <= w_faddr;
      end
    end
  end

  mips_mem_array #(.DEPTH(depth_words), .AW(AW)) u_array (
    .clk       (clk),
    .rst       (reset),
    .i_fa_idx  (w_i_idx),
    .o_fa_data (w_fa_data),
    .i_rd_idx  (w_d_idx),
    .i_rd_zero (!w_run || (w_d_cause != ERR_NONE)),
    .o_rd_data (data_in),
    .i_we      (w_we),
    .i_wa      (w_wa),
    .i_wd      (w_wd)
  );

  assign instr_in       = (w_run && w_i_cause == ERR_NONE) ? w_fa_data : 32'h0;
  assign ready          = r_ready;
  assign load_collision = r_coll;
  assign err_flag       = r_err_flag;
  assign err_cause      = r_err_cause;
  assign err_addr       = r_err_addr;

endmodule

// File: tb/tb_mips_memory.sv
// Directed bench for mips_memory: 16-word array at base 0 with clear-on-reset.
module tb_mips_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_addr, data_addr, data_out, load_addr, load_data;
  logic        data_rd_wr, load_en;
  logic [31:0] instr_in, data_in, err_addr;
  logic        ready, load_collision, err_flag;
  logic [1:0]  err_cause;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_memory #(.base_addr(32'h0), .depth_words(16), .clear_on_reset(1'b1)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_in(instr_in),
    .data_rd_wr(data_rd_wr), .data_addr(data_addr), .data_out(data_out), .data_in(data_in),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ready(ready), .load_collision(load_collision),
    .err_flag(err_flag), .err_cause(err_cause), .err_addr(err_addr)
  );

  typedef struct {
    logic        rd_wr;
    logic [31:0] daddr;
    logic [31:0] dout;
    logic [31:0] iaddr;
    logic        ld_en;
    logic [31:0] laddr;
    logic [31:0] ldata;
    logic [31:0] exp_instr;
    logic [31:0] exp_din;
    logic        exp_coll;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_rd_wr = 1'b1; data_addr = 32'h0; data_out = 32'h0;
    instr_addr = 32'h0; load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
  endtask

  // Counts edges from reset release until ready; fetch of word 15 must read 0 mid-clear
  task automatic wait_ready();
    int n;
    n = 0;
    instr_addr = 32'h3C;
    while (!ready && n < 64) begin
      tick();
      n++;
      if (n == 8) chk("clear_fetch_zero", instr_in, 32'h0);
    end
    chk("clear_latency", n, 16);
    instr_addr = 32'h0;
  endtask

  task automatic scan_zero();
    for (int i = 0; i < 16; i++) begin
      instr_addr = 32'(i * 4);
      #1;
      chk("word_cleared", instr_in, 32'h0);
    end
    instr_addr = 32'h0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", ready, 1'b0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_coll", load_collision, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    chk("rst_err_cause", err_cause, 2'b00);
    chk("rst_err_addr", err_addr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            rd_wr  daddr    dout           iaddr    ld_en laddr   ldata          exp_instr      exp_din        coll
    vecs[0] = '{1'b1, 32'h04, 32'h0,          32'h00, 1'b1, 32'h00, 32'h2408_0005, 32'h0,          32'h0,          1'b0};
    vecs[1] = '{1'b1, 32'h00, 32'h0,          32'h00, 1'b0, 32'h00, 32'h0,          32'h2408_0005, 32'h2408_0005, 1'b0};
    vecs[2] = '{1'b0, 32'h3C, 32'hDEAD_BEEF, 32'h3C, 1'b0, 32'h00, 32'h0,          32'h0,          32'h0,          1'b0};
    vecs[3] = '{1'b1, 32'h3C, 32'h0,          32'h3C, 1'b0, 32'h00, 32'h0,          32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h08, 32'h1,          32'h08, 1'b1, 32'h08, 32'h2,          32'h0,          32'h0,          1'b1};
    vecs[5] = '{1'b1, 32'h08, 32'h0,          32'h08, 1'b0, 32'h00, 32'h0,          32'h1,          32'h1,          1'b0};
    vecs[6] = '{1'b0, 32'h10, 32'h3,          32'h0C, 1'b1, 32'h0C, 32'h4,          32'h0,          32'h0,          1'b0};
    vecs[7] = '{1'b1, 32'h10, 32'h0,          32'h0C, 1'b0, 32'h00, 32'h0,          32'h4,          32'h3,          1'b0};
    vecs[8] = '{1'b1, 32'h20, 32'h0,          32'h20, 1'b1, 32'h20, 32'h55,         32'h0,          32'h0,          1'b0};
    vecs[9] = '{1'b1, 32'h20, 32'h0,          32'h20, 1'b0, 32'h00, 32'h0,          32'h55,         32'h55,         1'b0};

    idle();
    #2 reset = 1'b1;
    #1 chk_reset_vals();
    tick(); tick();
    reset = 1'b0;
    wait_ready();
    scan_zero();

    for (int i = 0; i < 10; i++) begin
      data_rd_wr = vecs[i].rd_wr; data_addr = vecs[i].daddr; data_out = vecs[i].dout;
      instr_addr = vecs[i].iaddr; load_en = vecs[i].ld_en;
      load_addr = vecs[i].laddr; load_data = vecs[i].ldata;
      #1;
      chk($sformatf("v%0d_instr", i), instr_in, vecs[i].exp_instr);
      tick();
      chk($sformatf("v%0d_data_in", i), data_in, vecs[i].exp_din);
      chk($sformatf("v%0d_coll", i), load_collision, vecs[i].exp_coll);
      chk($sformatf("v%0d_no_err", i), err_flag, 1'b0);
    end
    idle();

    // Misaligned fetch is the first fault
    instr_addr = 32'h2;
    #1 chk("mis_fetch_zero", instr_in, 32'h0);
    tick();
    chk("mis_err_flag", err_flag, 1'b1);
    chk("mis_err_cause", err_cause, 2'b01);
    chk("mis_err_addr", err_addr, 32'h2);
    instr_addr = 32'h0; data_addr = 32'h40;
    tick();
    chk("rng_din_zero", data_in, 32'h0);
    chk("sticky_cause", err_cause, 2'b01);
    chk("sticky_addr", err_addr, 32'h2);
    data_addr = 32'h0;
    tick();
    chk("host_word0", data_in, 32'h2408_0005);

    // Async reset while running and faulted
    #2 reset = 1'b1;
    #1 chk_reset_vals();
    tick();
    reset = 1'b0;
    repeat (7) tick();
    #2 reset = 1'b1;
    #1 chk("midclr_ready", ready, 1'b0);
    chk("midclr_din", data_in, 32'h0);
    tick();
    reset = 1'b0;
    wait_ready();
    scan_zero();

    // Out-of-range load beats a simultaneous misaligned fetch
    data_rd_wr = 1'b0; data_addr = 32'h0; data_out = 32'h77;
    tick();
    data_rd_wr = 1'b1;
    tick();
    chk("store_word0", data_in, 32'h77);
    data_addr = 32'h40; instr_addr = 32'h6;
    tick();
    chk("rng_data_in", data_in, 32'h0);
    chk("rng_err_flag", err_flag, 1'b1);
    chk("rng_err_cause", err_cause, 2'b10);
    chk("rng_err_addr", err_addr, 32'h40);
    instr_addr = 32'h0; data_addr = 32'h5;
    tick();
    chk("late_mis_cause", err_cause, 2'b10);
    chk("late_mis_addr", err_addr, 32'h40);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
